// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - four-voice sample scheduler and saturating mixer over a shared ROM
module voice_scheduler #(
  parameter int SAMPLE_LEN = 4000,
  parameter int ADDR_W     = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic [3:0]        trig,
  input  logic [3:0]        mute,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [3:0]        busy,
  output logic [7:0]        mix_out,
  output logic [7:0]        mix_u,
  output logic              mix_valid,
  output logic              overrun
);

  localparam int                POS_W    = (SAMPLE_LEN > 1) ? $clog2(SAMPLE_LEN) : 1;
  localparam logic [POS_W-1:0]  POS_LAST = POS_W'(SAMPLE_LEN - 1);
  localparam logic [ADDR_W-1:0] LEN_A    = ADDR_W'(SAMPLE_LEN);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_OUT} state_t;

  state_t           state, state_nx;
  logic [1:0]       vox, vox_nx;
  logic [3:0]       active;
  logic [POS_W-1:0] pos [4];
  logic [7:0]       acc, acc_nx;
  logic [8:0]       sum;
  logic [7:0]       sum_sat;

  // Sign-extended 9-bit sum; overflow of the 8-bit range shows as sum[8] != sum[7].
  always_comb begin
    sum     = {acc[7], acc} + {mem_data[7], mem_data};
    sum_sat = sum[7:0];
    if (sum[8] != sum[7]) sum_sat = sum[8] ? 8'h80 : 8'h7F;
  end

  // Next-state, ROM strobe/address and accumulator update for the frame walk.
  always_comb begin
    state_nx = state;
    vox_nx   = vox;
    acc_nx   = acc;
    mem_rd   = 1'b0;
    mem_addr = '0;
    case (state)
      S_IDLE: begin
        if (sample_tick) begin
          state_nx = S_ADDR;
          vox_nx   = 2'd0;
          acc_nx   = 8'h00;
        end
      end
      S_ADDR: begin
        if (active[vox]) begin
          mem_rd   = 1'b1;
          mem_addr = ADDR_W'(vox) * LEN_A + ADDR_W'(pos[vox]);
        end
        state_nx = S_DATA;
      end
      S_DATA: begin
        if (active[vox] && !mute[vox]) acc_nx = sum_sat;
        if (vox == 2'd3) begin
          state_nx = S_OUT;
        end else begin
          state_nx = S_ADDR;
          vox_nx   = vox + 2'd1;
        end
      end
      S_OUT: begin
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Frame state, accumulator, mix output register and sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      vox       <= 2'd0;
      acc       <= 8'h00;
      mix_out   <= 8'h00;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      vox       <= vox_nx;
      acc       <= acc_nx;
      mix_valid <= (state == S_OUT);
      if (state == S_OUT) mix_out <= acc;
      if (sample_tick && state != S_IDLE) overrun <= 1'b1;
    end
  end

  // Per-voice play position; a trigger always wins over advance or end-of-sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= 4'b0000;
      for (int v = 0; v < 4; v++) pos[v] <= '0;
    end else begin
      for (int v = 0; v < 4; v++) begin
        if (trig[v]) begin
          active[v] <= 1'b1;
          pos[v]    <= '0;
        end else if (state == S_DATA && vox == 2'(v) && active[v]) begin
          if (pos[v] == POS_LAST) begin
            active[v] <= 1'b0;
            pos[v]    <= '0;
          end else begin
            pos[v] <= pos[v] + POS_W'(1);
          end
        end
      end
    end
  end

  assign busy  = active;
  assign mix_u = mix_out ^ 8'h80;

endmodule

// File: tb/tb_voice_scheduler.sv
// tb/tb_voice_scheduler.sv - scoreboard bench for voice_scheduler
module tb_voice_scheduler;

  localparam int SAMPLE_LEN = 4;
  localparam int ADDR_W     = 14;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sample_tick = 1'b0;
  logic [3:0]        trig = 4'b0000;
  logic [3:0]        mute = 4'b0000;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data = 8'h00;
  logic [3:0]        busy;
  logic [7:0]        mix_out;
  logic [7:0]        mix_u;
  logic              mix_valid;
  logic              overrun;

  voice_scheduler #(.SAMPLE_LEN(SAMPLE_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .trig(trig), .mute(mute),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .busy(busy),
    .mix_out(mix_out), .mix_u(mix_u), .mix_valid(mix_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mix;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rom [16];
  int         addr_log[$];
  int         cyc = 0;
  int         valid_count = 0;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One-cycle-latency ROM model
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_data <= rom[mem_addr[3:0]];
  end

  // Monitor: logs ROM reads, pops the scoreboard on every mix_valid
  always @(negedge clk) begin
    if (mem_rd) addr_log.push_back(int'(mem_addr));
    if (mix_valid) begin
      valid_count++;
      if (sb.size() == 0) begin
        chk("unexpected_mix_valid", 32'(mix_out), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mix_out", 32'(mix_out), 32'(e.mix));
        chk("mix_u", 32'(mix_u), 32'(e.mix ^ 8'h80));
        chk("latency", 32'(cyc - e.cyc), 32'd10);
      end
    end
  end

  task automatic fill(input int lo, input int hi, input logic [7:0] val);
    for (int i = lo; i <= hi; i++) rom[i] = val;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    addr_log.delete();
  endtask

  task automatic pulse_trig(input logic [3:0] m);
    @(negedge clk);
    trig = m;
    @(negedge clk);
    trig = 4'b0000;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      bad++;
      total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_tick(input logic [7:0] exp_mix, input logic [3:0] trg);
    exp_t e;
    @(negedge clk);
    addr_log.delete();
    sample_tick = 1'b1;
    trig = trg;
    e.mix = exp_mix;
    e.cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    sample_tick = 1'b0;
    trig = 4'b0000;
    drain();
  endtask

  task automatic chk_addr(input string name, input int a);
    chk({name, "_cnt"}, 32'(addr_log.size()), 32'd1);
    if (addr_log.size() > 0) chk(name, 32'(addr_log[0]), 32'(a));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mix_out"}, 32'(mix_out), 32'h00);
    chk({tag, "_mix_u"}, 32'(mix_u), 32'h80);
    chk({tag, "_mix_valid"}, 32'(mix_valid), 32'd0);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    int vc;
    exp_t e;
    fill(0, 15, 8'h00);
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;

    // Single voice
    do_reset();
    fill(0, 3, 8'h10);
    pulse_trig(4'b0001);
    do_tick(8'h10, 4'b0000);
    chk_addr("single_addr", 0);
    chk("single_busy", 32'(busy), 32'b0001);

    // Saturation, high, low, and per-addition clamping
    do_reset();
    fill(0, 15, 8'h50);
    pulse_trig(4'b1111);
    do_tick(8'h7F, 4'b0000);
    fill(0, 15, 8'hB0);
    do_tick(8'h80, 4'b0000);
    fill(0, 7, 8'h70);
    fill(8, 11, 8'h90);
    fill(12, 15, 8'h00);
    do_tick(8'h0F, 4'b0000);

    // End of sample on voice 1
    do_reset();
    rom[4] = 8'h01; rom[5] = 8'h02; rom[6] = 8'h03; rom[7] = 8'h04;
    pulse_trig(4'b0010);
    for (int i = 0; i < 4; i++) begin
      do_tick(8'(i + 1), 4'b0000);
      chk_addr("eos_addr", 4 + i);
      if (i == 2) chk("eos_busy_mid", 32'(busy), 32'b0010);
    end
    chk("eos_busy_end", 32'(busy), 32'b0000);
    do_tick(8'h00, 4'b0000);
    chk("eos_no_rd", 32'(addr_log.size()), 32'd0);

    // Retrigger and mute on voice 2
    do_reset();
    rom[8] = 8'h05; rom[9] = 8'h06; rom[10] = 8'h07; rom[11] = 8'h08;
    pulse_trig(4'b0100);
    do_tick(8'h05, 4'b0000);
    do_tick(8'h06, 4'b0000);
    do_tick(8'h07, 4'b0000);
    pulse_trig(4'b0100);
    do_tick(8'h05, 4'b0000);
    chk_addr("retrig_addr", 8);
    mute = 4'b0100;
    do_tick(8'h00, 4'b0000);
    chk_addr("mute_addr", 9);
    mute = 4'b0000;
    do_tick(8'h07, 4'b0000);
    chk_addr("unmute_addr", 10);

    // Trigger on the same edge as the tick restarts voice 3 at pos 0
    do_reset();
    rom[12] = 8'h09; rom[13] = 8'h0A; rom[14] = 8'h0B; rom[15] = 8'h0C;
    pulse_trig(4'b1000);
    do_tick(8'h09, 4'b0000);
    do_tick(8'h0A, 4'b0000);
    do_tick(8'h09, 4'b1000);
    chk_addr("same_edge_addr", 12);

    // Trigger during DATA(0) overrides the advance
    do_reset();
    rom[0] = 8'h01; rom[1] = 8'h02; rom[2] = 8'h03; rom[3] = 8'h04;
    pulse_trig(4'b0001);
    do_tick(8'h01, 4'b0000);
    @(negedge clk);
    sample_tick = 1'b1;
    e.mix = 8'h02;
    e.cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    trig = 4'b0001;
    @(negedge clk);
    trig = 4'b0000;
    drain();
    do_tick(8'h01, 4'b0000);
    chk_addr("data_trig_addr", 0);

    // Overrun: second tick four cycles after the first
    do_reset();
    fill(0, 3, 8'h22);
    pulse_trig(4'b0001);
    vc = valid_count;
    @(negedge clk);
    sample_tick = 1'b1;
    e.mix = 8'h22;
    e.cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    drain();
    repeat (15) @(negedge clk);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("overrun_one_valid", 32'(valid_count - vc), 32'd1);
    do_reset();
    chk("overrun_cleared", 32'(overrun), 32'd0);

    // Reset in the middle of DATA(1)
    do_reset();
    fill(0, 15, 8'h33);
    pulse_trig(4'b0011);
    do_tick(8'h66, 4'b0000);
    vc = valid_count;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("midrst_no_valid", 32'(valid_count - vc), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 Parameter SAMPLE_LEN, default 4000, samples per voice in the shared sample ROM.
REQ-002 Parameter ADDR_W, default 14, shared ROM address width; 4*SAMPLE_LEN SHALL fit in ADDR_W bits.
REQ-003 clk  input  1  system clock (2 MHz domain).
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 sample_tick  input  1  one-cycle pulse that starts one mixing frame (16 kHz rate).
REQ-006 trig  input  4  one-cycle per-voice start pulses; bit 3 kick, bit 2 clap, bit 1 hihat, bit 0 snare.
REQ-007 mute  input  4  per-voice level mute mask; 1 = voice advances but contributes 0.
REQ-008 mem_addr  output  ADDR_W  shared ROM read address.
REQ-009 mem_rd  output  1  ROM read strobe; data SHALL be valid on mem_data exactly one cycle later.
REQ-010 mem_data  input  8  signed two's-complement ROM sample.
REQ-011 busy  output  4  per-voice active flags.
REQ-012 mix_out  output  8  signed saturated mix of the last completed frame.
REQ-013 mix_u  output  8  mix_out XOR 8'h80 (offset-binary, for PWM duty).
REQ-014 mix_valid  output  1  one-cycle pulse when mix_out updates.
REQ-015 overrun  output  1  sticky flag: sample_tick arrived while a frame was in progress.

Function
REQ-016 Each voice v SHALL hold an active bit and a position counter pos_v (0..SAMPLE_LEN-1); voice base address = v*SAMPLE_LEN.
REQ-017 trig[v] high SHALL set active_v=1 and pos_v=0 on the next edge, whether the voice is idle or playing (retrigger restarts).
REQ-018 FSM states: IDLE, ADDR(v), DATA(v), OUT; v scans 0,1,2,3 in order.
REQ-019 IDLE -> ADDR(0) on sample_tick; accumulator cleared to 0 on that edge.
REQ-020 ADDR(v): mem_rd=1 and mem_addr=v*SAMPLE_LEN+pos_v if active_v, else mem_rd=0 and mem_addr=0; next state DATA(v).
REQ-021 DATA(v): if active_v and mute[v]=0, acc <= sat8(acc + mem_data); else acc unchanged; next state ADDR(v+1), or OUT after v=3.
REQ-022 DATA(v) for an active voice SHALL advance pos_v by 1; at pos_v=SAMPLE_LEN-1 it SHALL clear active_v and reset pos_v to 0 instead.
REQ-023 trig[v] coinciding with DATA(v) or end-of-sample SHALL take priority: active_v=1, pos_v=0.
REQ-024 sat8: signed 9-bit sum clamped to [-128,127] after every addition (not only at end).
REQ-025 OUT: mix_out <= acc, mix_valid=1 for that cycle; next state IDLE.
REQ-026 Frame latency fixed regardless of active voices: sample_tick at edge T -> mix_valid high in the cycle after edge T+9; each voice slot SHALL be exactly 2 cycles.
REQ-027 sample_tick in any state other than IDLE SHALL be ignored and SHALL set overrun=1; overrun cleared only by reset.
REQ-028 sample_tick and trig[v] on the same edge: trig applied first, so the frame reads pos_v=0.
REQ-029 mix_u SHALL be combinational from mix_out; all other outputs registered or decoded from registered state.

Reset
REQ-030 reset asserted SHALL immediately force: FSM IDLE, all active=0, all pos=0, acc=0, mix_out=0, mix_u=8'h80, mix_valid=0, mem_rd=0, mem_addr=0, busy=0, overrun=0.
REQ-031 reset mid-frame SHALL abort the frame with no mix_valid pulse; first frame after release begins on the next sample_tick.

Verification
REQ-032 Single voice: trig=4'b0001, ROM snare all 8'h10, tick -> mem_addr=0 in ADDR(0), mix_out=8'h10, mix_valid 10 cycles after tick, busy=4'b0001.
REQ-033 Saturation: all four voices triggered, ROM data 8'h50 each, tick -> mix_out=8'h7F, mix_u=8'hFF; with 8'hB0 each -> mix_out=8'h80, mix_u=8'h00.
REQ-034 End of sample: SAMPLE_LEN=4, one voice, 4 ticks -> addresses base+0..3, busy clears after 4th frame, 5th frame mem_rd never high, mix_out=0.
REQ-035 Retrigger/mute: retrigger voice 2 at pos 3 -> next frame mem_addr=2*SAMPLE_LEN; mute[2]=1 -> pos still advances, mix_out=0.
REQ-036 Overrun: second tick 4 cycles after first -> overrun=1, exactly one mix_valid; reset clears overrun.
REQ-037 Reset mid-frame in DATA(1) -> all outputs at reset values, no mix_valid, busy=0.
